// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serializer/collector pair
//
// Purpose: state encoding for the word collector FSM and the default serial
// word length shared with the transmit-side bit-serializer.
package serial_pkg;

  typedef enum logic {
    IDLE,
    COLLECT
  } collect_state_t;

  localparam int SERIAL_WORD_W = 20;

endpackage

// File: rtl/out_slot_reg.sv
// rtl/out_slot_reg.sv - one-entry ready/valid holding register with overrun flag
//
// Purpose: holds the most recently completed word until the consumer takes it.
// A new word arriving while the slot is full and not being consumed is dropped
// and recorded in a sticky overrun flag.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   load_valid     a completed word is offered this cycle
//   load_word      the completed word
//   out_ready      consumer accepts out_word this cycle
//   clr_overrun    clears the sticky overrun flag (a same-cycle set wins)
//   out_word       held word
//   out_valid      out_word is unconsumed
//   overrun        sticky: a completed word was dropped
module out_slot_reg #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_word,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             consume;
  logic             drop;

  assign consume = valid_q & out_ready;

  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    drop      = 1'b0;
    if (load_valid) begin
      // A consume in the same cycle frees the slot, so back-to-back words
      // stream through without a bubble.
      if (!valid_q || consume) begin
        word_d  = load_word;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end

    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_word  = word_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - reassembles an LSB-first serial stream into words
//
// Purpose: collects WIDTH bits following an explicit start strobe into a word
// and hands completed words to a one-entry ready/valid output slot.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   in_valid       in_bit (and in_start) are valid this cycle
//   in_bit         serial data bit
//   in_start       in_bit is bit 0 of a new word
//   out_ready      consumer accepts out_word this cycle
//   clr_overrun    clears the sticky overrun flag
//   out_word       assembled word, bit i = i-th bit after start
//   out_valid      out_word holds an unconsumed word
//   busy           a word is partially collected
//   overrun        sticky: a completed word was dropped
module serial_word_collector
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_start,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  collect_state_t   state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] bits_q, bits_d;
  logic             complete;
  logic [WIDTH-1:0] complete_word;

  // The final bit goes straight to the output slot alongside the bits already
  // stored, so the word is available one edge after its last bit.
  assign complete_word = {in_bit, bits_q[WIDTH-2:0]};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    bits_d   = bits_q;
    complete = 1'b0;
    if (in_valid) begin
      if (in_start) begin
        // Start always (re)aligns; a partial word is abandoned silently.
        bits_d[0] = in_bit;
        idx_d     = CNT_W'(1);
        state_d   = COLLECT;
      end else if (state_q == COLLECT) begin
        // Bits are written by index, so leftovers of an aborted word are
        // always overwritten before the word can complete.
        bits_d[idx_q] = in_bit;
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          state_d  = IDLE;
          complete = 1'b1;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bits_q  <= bits_d;
    end
  end

  assign busy = (state_q == COLLECT);

  out_slot_reg #(
    .WIDTH(WIDTH)
  ) u_out_slot (
    .clk        (clk),
    .reset      (reset),
    .load_valid (complete),
    .load_word  (complete_word),
    .out_ready  (out_ready),
    .clr_overrun(clr_overrun),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_word_collector.sv
// tb/tb_serial_word_collector.sv - directed self-checking bench for serial_word_collector
module tb_serial_word_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_start = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [19:0] out_word;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;

  serial_word_collector #(.WIDTH(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_start   (in_start),
    .out_ready  (out_ready),
    .clr_overrun(clr_overrun),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // One clock cycle: inputs applied at negedge, outputs observable 1 time
  // unit after the rising edge when this task returns.
  task automatic step(input logic v, input logic b, input logic s);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    in_start = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Bits 0..last of w, bit 0 carrying the start strobe.
  task automatic send_bits(input logic [19:0] w, input int last);
    for (int i = 0; i <= last; i++) step(1'b1, w[i], (i == 0));
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || out_word !== 20'h0) begin
      miscompares++;
      $display("FAIL reset: valid=%b busy=%b ovr=%b word=%h, required 0 0 0 00000",
               out_valid, busy, overrun, out_word);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send_bits(20'hA5C3F, 0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: busy=%b, required 1", busy);
    end
    for (int i = 1; i <= 18; i++) step(1'b1, 1'(20'hA5C3F >> i), 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early: out_valid=%b before last bit, required 0", out_valid);
    end
    step(1'b1, 1'b1, 1'b0);  // bit 19 of A5C3F is 1
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 20'hA5C3F || overrun !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_word: valid=%b word=%h ovr=%b busy=%b, required 1 a5c3f 0 0",
               out_valid, out_word, overrun, busy);
    end
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_pulse: out_valid=%b after consume, required 0", out_valid);
    end
  endtask

  task automatic test_gaps;
    logic [19:0] w;
    logic        gap_busy_ok;
    w = 20'hA5C3F;
    gap_busy_ok = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, w[i], (i == 0));
      if (i == 7 || i == 15) begin
        for (int g = 0; g < ((i == 7) ? 3 : 5); g++) begin
          step(1'b0, 1'b1, 1'b1);  // in_start ignored while in_valid low
          if (busy !== 1'b1 || out_valid !== 1'b0) gap_busy_ok = 1'b0;
        end
      end
    end
    vectors++;
    if (gap_busy_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL gaps_busy: busy/valid wrong during gap, required busy=1 valid=0");
    end
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 20'hA5C3F) begin
      miscompares++;
      $display("FAIL gaps_word: valid=%b word=%h, required 1 a5c3f", out_valid, out_word);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort;
    int valid_cycles;
    logic [19:0] seen;
    valid_cycles = 0;
    seen = 20'h0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, (i == 0));
      if (out_valid) valid_cycles++;
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (i == 0), (i == 0));
      if (out_valid) begin
        valid_cycles++;
        seen = out_word;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (out_valid) valid_cycles++;
    end
    vectors++;
    if (valid_cycles != 1 || seen !== 20'h00001 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: valid_cycles=%0d word=%h ovr=%b, required 1 00001 0",
               valid_cycles, seen, overrun);
    end
  endtask

  task automatic test_overrun;
    out_ready = 1'b0;
    send_bits(20'h12345, 19);
    send_bits(20'h6789A, 19);
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 20'h12345 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_hold: valid=%b word=%h ovr=%b, required 1 12345 1",
               out_valid, out_word, overrun);
    end
    out_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || out_word !== 20'h12345 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_consume: valid=%b word=%h ovr=%b, required 0 12345 1",
               out_valid, out_word, overrun);
    end
    clr_overrun = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_overrun = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
    end
  endtask

  task automatic test_set_wins;
    logic [19:0] w;
    w = 20'h0F0F0;
    out_ready = 1'b0;
    send_bits(20'h55555, 19);
    send_bits(w, 18);
    clr_overrun = 1'b1;
    step(1'b1, w[19], 1'b0);
    clr_overrun = 1'b0;
    vectors++;
    if (overrun !== 1'b1 || out_word !== 20'h55555) begin
      miscompares++;
      $display("FAIL set_wins: ovr=%b word=%h, required 1 55555", overrun, out_word);
    end
    out_ready = 1'b1;
    clr_overrun = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_overrun = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [19:0] w;
    w = 20'h22222;
    out_ready = 1'b0;
    send_bits(20'h11111, 19);
    send_bits(w, 18);
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 20'h11111) begin
      miscompares++;
      $display("FAIL b2b_hold: valid=%b word=%h, required 1 11111", out_valid, out_word);
    end
    out_ready = 1'b1;
    step(1'b1, w[19], 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 20'h22222 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_word: valid=%b word=%h ovr=%b, required 1 22222 0",
               out_valid, out_word, overrun);
    end
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    send_bits(20'h0ABCD, 19);
    send_bits(20'hFFFFF, 12);
    vectors++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre: valid=%b busy=%b, required 1 1", out_valid, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_word !== 20'h0) begin
      miscompares++;
      $display("FAIL areset_async: valid=%b busy=%b word=%h, required 0 0 00000",
               out_valid, busy, out_word);
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    send_bits(20'h3C3C3, 19);
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 20'h3C3C3 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_after: valid=%b word=%h ovr=%b, required 1 3c3c3 0",
               out_valid, out_word, overrun);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_abort();
    test_overrun();
    test_set_wins();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Receive-side counterpart of the team's bit-serializer. It reassembles a serial bit stream, LSB first at one bit per accepted cycle, into WIDTH-bit words.
- Each completed word is presented on a ready/valid output register for the downstream consumer, such as the RSA operand loader.
- Frame alignment comes from an explicit start strobe. Overflow of the single output slot is flagged, not silently lost.

Parameters:
- WIDTH, 20, word length in bits; must be at least 2.
- CNT_W, $clog2(WIDTH), derived localparam for the bit-index counter width; not overridable.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  serial data bit.
- in_start  in  1  qualified by in_valid; marks in_bit as bit 0 of a new word.
- out_ready  in  1  consumer accepts word this cycle.
- clr_overrun  in  1  clears the sticky overrun flag.
- out_word  out  WIDTH  assembled word; bit i = i-th bit received after start.
- out_valid  out  1  out_word holds an unconsumed word.
- busy  out  1  a word is partially collected (state COLLECT).
- overrun  out  1  sticky: a completed word was dropped.

Behaviour:
- Reset (async assert, sync release): state IDLE, bit index 0, shift register 0, out_word 0, out_valid 0, overrun 0, busy 0.
- States:
  - IDLE: waiting for a start bit.
  - COLLECT: bits 1..WIDTH-1 pending.
- IDLE:
  - in_valid and not in_start: bit ignored.
  - in_valid and in_start: store in_bit at index 0, index := 1, go to COLLECT.
- COLLECT, in_valid and not in_start:
  - Store in_bit at the current index.
  - Index < WIDTH-1: increment.
  - Index == WIDTH-1: word complete; index := 0, go to IDLE.
- COLLECT, in_valid and in_start: abort the partial word without flagging it. Restart with in_bit as bit 0, index := 1, stay in COLLECT.
- in_valid low: no state change. Gaps between bits are allowed indefinitely.
- Store rule: each bit is written to its own index, not shifted. Stale bits from aborted words never leak, because a word completes only after all WIDTH indices have been written since start.
- Latency: the last bit is accepted at edge N; out_valid=1 and out_word are valid after edge N, visible in cycle N+1.
- Output slot, evaluated at each edge:
  - Consume: out_valid and out_ready.
  - Completion while slot empty, or completion with consume in the same cycle: load the new word, out_valid stays/goes 1. This gives back-to-back words with no bubble.
  - Completion while slot full and no consume: new word dropped, out_word unchanged, overrun := 1.
  - Consume without completion: out_valid := 0. out_word keeps its last value.
- overrun is sticky until clr_overrun or reset. If set and clear occur in the same cycle, set wins.
- out_word must not change while out_valid=1 and out_ready=0.
- in_start is ignored when in_valid=0.
- busy is 1 exactly in COLLECT.
- Reset mid-word: partial word discarded and out_valid cleared immediately (async).

Decomposition:
- Package serial_pkg, shared with the serializer:
  - typedef enum logic {IDLE, COLLECT} collect_state_t.
  - localparam SERIAL_WORD_W = 20.
- One sub-module: out_slot_reg, a one-entry ready/valid holding register with load/consume/overrun logic.
- Collector FSM and index counter stay in the top.

Test Plan:
- Reset, then start plus 20 consecutive bits forming 20'hA5C3F, LSB first, out_ready=1 → out_valid pulses 1 cycle after the 20th bit; out_word=20'hA5C3F; overrun=0.
- Same word with in_valid low for 3 cycles after bit 7 and 5 cycles after bit 15 → out_word=20'hA5C3F; busy=1 throughout gaps.
- Start, 10 bits, then a new start followed by 20 bits of 20'h00001 → out_word=20'h00001 only; exactly one out_valid; no overrun.
- out_ready=0; send 20'h12345 then 20'h6789A → out_word stays 20'h12345, overrun=1. Assert out_ready → word consumed. clr_overrun → overrun=0.
- out_ready=0 holding 20'h11111; raise out_ready on the exact cycle 20'h22222 completes → out_valid stays 1, out_word=20'h22222, overrun=0.
- Assert reset asynchronously mid-word (after bit 12) and with out_valid=1 → out_valid=0, busy=0 without a clock edge. A following full word is received correctly.
